// File: rtl/magnitude_frame_ctrl.sv
// magnitude_frame_ctrl: collects a frame of audio samples, streams it into the
// magnitude core one sample per clock, and reports the strongest bin in the
// lower half-spectrum (DC excluded).
// Optional feature macro: MAGNITUDE_CTRL_NOISE_GATE_EN (suppress reports whose
// peak magnitude is below GATE_LEVEL).
`timescale 1ns/1ps

module magnitude_frame_ctrl #(
    parameter int unsigned FRAME_LEN   = 8192,
    parameter int unsigned MAG_LATENCY = 4,
    parameter logic [31:0] GATE_LEVEL  = 32'h0001_0000,
    localparam int unsigned ADDR_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       sample_in,
    input  logic              sample_valid,
    output logic [15:0]       mag_data_in,
    input  logic [31:0]       mag_result,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [31:0]       peak_mag,
    output logic              peak_valid,
    output logic              busy,
    output logic [15:0]       overrun_count
);

    localparam int unsigned       FL_W     = (MAG_LATENCY > 1) ? $clog2(MAG_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] HALF_IDX = ADDR_W'(FRAME_LEN / 2);
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(MAG_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_REPORT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [15:0]         mag_data_q, mag_data_d;
    logic [31:0]         max_mag_q, max_mag_d;
    logic [ADDR_W-1:0]   max_bin_q, max_bin_d;
    logic [ADDR_W-1:0]   peak_bin_q, peak_bin_d;
    logic [31:0]         peak_mag_q, peak_mag_d;
    logic                peak_valid_q, peak_valid_d;
    logic                busy_q, busy_d;
    logic [15:0]         overrun_q, overrun_d;

    logic [15:0]         frame_buf_q [FRAME_LEN];
    logic                tag_vld_q   [MAG_LATENCY];
    logic [ADDR_W-1:0]   tag_idx_q   [MAG_LATENCY];

    logic                buf_we;
    logic [ADDR_W-1:0]   rd_addr;
    logic                res_vld;
    logic [ADDR_W-1:0]   res_idx;
    logic                res_searched;
    logic                report_ok;

    assign buf_we       = (state_q == S_FILL) && enable && sample_valid;
    assign rd_addr      = (state_q == S_STREAM) ? (rd_ptr_q + ADDR_W'(1)) : '0;
    assign res_vld      = tag_vld_q[MAG_LATENCY-1];
    assign res_idx      = tag_idx_q[MAG_LATENCY-1];
    assign res_searched = res_vld && (res_idx != '0) && (res_idx < HALF_IDX);

`ifdef MAGNITUDE_CTRL_NOISE_GATE_EN
    assign report_ok = (max_mag_q >= GATE_LEVEL);
`else
    logic unused_gate_level;
    assign unused_gate_level = ^GATE_LEVEL;
    assign report_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; enable only gates IDLE/FILL, a started frame always completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_FILL;
            S_FILL: begin
                if (!enable)                              state_d = S_IDLE;
                else if (sample_valid && wr_ptr_q == LAST_IDX) state_d = S_STREAM;
            end
            S_STREAM: if (rd_ptr_q == LAST_IDX) state_d = S_FLUSH;
            S_FLUSH:  if (flush_cnt_q == FL_LAST) state_d = S_REPORT;
            S_REPORT: state_d = enable ? S_FILL : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath/output next values: pointers, prefetched stream data, peak search, reports
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        flush_cnt_d  = '0;
        mag_data_d   = '0;
        max_mag_d    = max_mag_q;
        max_bin_d    = max_bin_q;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = 1'b0;
        overrun_d    = overrun_q;
        busy_d       = (state_d != S_IDLE);

        if (state_d == S_FILL && state_q != S_FILL) wr_ptr_d = '0;
        else if (buf_we)                            wr_ptr_d = wr_ptr_q + ADDR_W'(1);

        if (state_q == S_FILL && state_d == S_STREAM) begin
            rd_ptr_d   = '0;
            mag_data_d = frame_buf_q[rd_addr];
            max_mag_d  = '0;
            max_bin_d  = '0;
        end else if (state_q == S_STREAM) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (rd_ptr_q != LAST_IDX) mag_data_d = frame_buf_q[rd_addr];
        end

        if (state_q == S_FLUSH) flush_cnt_d = flush_cnt_q + FL_W'(1);

        if (res_searched && mag_result > max_mag_q) begin
            max_mag_d = mag_result;
            max_bin_d = res_idx;
        end

        if (state_q == S_FLUSH && state_d == S_REPORT && report_ok) begin
            peak_valid_d = 1'b1;
            peak_bin_d   = max_bin_q;
            peak_mag_d   = max_mag_q;
        end

        if (sample_valid && (state_q == S_STREAM || state_q == S_FLUSH || state_q == S_REPORT)
            && overrun_q != 16'hFFFF)
            overrun_d = overrun_q + 16'd1;
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            flush_cnt_q  <= '0;
            mag_data_q   <= '0;
            max_mag_q    <= '0;
            max_bin_q    <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            flush_cnt_q  <= flush_cnt_d;
            mag_data_q   <= mag_data_d;
            max_mag_q    <= max_mag_d;
            max_bin_q    <= max_bin_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    // Frame buffer write port
    always_ff @(posedge clk) begin
        if (buf_we) frame_buf_q[wr_ptr_q] <= sample_in;
    end

    // Result alignment: tag each issued sample with valid and index for MAG_LATENCY cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAG_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
                tag_idx_q[i] <= '0;
            end
        end else begin
            for (int i = MAG_LATENCY - 1; i > 0; i--) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
            tag_vld_q[0] <= (state_q == S_STREAM);
            tag_idx_q[0] <= rd_ptr_q;
        end
    end

    assign mag_data_in   = mag_data_q;
    assign peak_bin      = peak_bin_q;
    assign peak_mag      = peak_mag_q;
    assign peak_valid    = peak_valid_q;
    assign busy          = busy_q;
    assign overrun_count = overrun_q;

endmodule

// File: tb/tb_magnitude_frame_ctrl.sv
// Self-checking bench for magnitude_frame_ctrl (FRAME_LEN=16, MAG_LATENCY=4).
// Reference model: argmax over bins 1..7 of the accepted frame, fixed report timing.
`timescale 1ns/1ps

module tb_magnitude_frame_ctrl;

    localparam int unsigned FLEN = 16;
    localparam int unsigned LAT  = 4;
    localparam logic [31:0] GATE = 32'h0000_0100;
    localparam int          PROC = FLEN + LAT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] mag_data_in;
    logic [31:0] mag_result;
    logic [3:0]  peak_bin;
    logic [31:0] peak_mag;
    logic        peak_valid;
    logic        busy;
    logic [15:0] overrun_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] frame [FLEN];
    logic [15:0] ov_exp;
    logic [3:0]  exp_bin;
    logic [31:0] exp_mag;
    logic [15:0] core_pipe [LAT];

    always #5 clk = ~clk;

    magnitude_frame_ctrl #(
        .FRAME_LEN   (FLEN),
        .MAG_LATENCY (LAT),
        .GATE_LEVEL  (GATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .mag_data_in   (mag_data_in),
        .mag_result    (mag_result),
        .peak_bin      (peak_bin),
        .peak_mag      (peak_mag),
        .peak_valid    (peak_valid),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    // Magnitude core stub: zero-extended input, LAT cycles later
    always @(posedge clk) begin
        core_pipe[0] <= mag_data_in;
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign mag_result = {16'h0, core_pipe[LAT-1]};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: strongest bin among 1..FLEN/2-1, ties keep the lowest bin
    task automatic model_peak(output logic rep);
        logic [15:0] best;
        logic [3:0]  bin;
        best = 16'h0;
        bin  = 4'h0;
        for (int b = 1; b < FLEN / 2; b++) begin
            if (frame[b] > best) begin
                best = frame[b];
                bin  = 4'(b);
            end
        end
`ifdef MAGNITUDE_CTRL_NOISE_GATE_EN
        rep = ({16'h0, best} >= GATE);
`else
        rep = 1'b1;
`endif
        if (rep) begin
            exp_bin = bin;
            exp_mag = {16'h0, best};
        end
    endtask

    // Fill one frame (DUT must be in FILL), then watch stream/flush/report.
    // ovr_mode: 0 none, 1 directed (3 in STREAM, 1 in REPORT), 2 random.
    task automatic run_frame(input int gap_pct, input int ovr_mode);
        int   sent;
        int   pv_n;
        int   pv_cnt;
        logic drv;
        logic rep;
        sent = 0;
        while (sent < FLEN) begin
            if ($urandom_range(99) < gap_pct) begin
                sample_valid = 1'b0;
                sample_in    = 16'($urandom);
            end else begin
                sample_valid = 1'b1;
                sample_in    = frame[sent];
                sent++;
            end
            tick();
        end
        pv_n   = 0;
        pv_cnt = 0;
        for (int n = 1; n <= PROC; n++) begin
            if (peak_valid) begin
                pv_cnt++;
                pv_n = n;
            end
            if (n <= FLEN) check_eq("stream_data", 32'(mag_data_in), 32'(frame[n-1]));
            else           check_eq("flush_data", 32'(mag_data_in), 32'h0);
            if (n == PROC) check_eq("busy_report", 32'(busy), 32'h1);
            case (ovr_mode)
                1:       drv = (n == 2 || n == 5 || n == 9 || n == PROC);
                2:       drv = ($urandom_range(99) < 30);
                default: drv = 1'b0;
            endcase
            sample_valid = drv;
            sample_in    = 16'($urandom);
            if (drv && ov_exp != 16'hFFFF) ov_exp = ov_exp + 16'd1;
            tick();
        end
        sample_valid = 1'b0;
        model_peak(rep);
        check_eq("pv_pulses", 32'(pv_cnt), rep ? 32'h1 : 32'h0);
        check_eq("pv_cycle", 32'(pv_n), rep ? 32'(PROC) : 32'h0);
        check_eq("peak_bin", 32'(peak_bin), 32'(exp_bin));
        check_eq("peak_mag", peak_mag, exp_mag);
        check_eq("overrun", 32'(overrun_count), 32'(ov_exp));
        check_eq("pv_after", 32'(peak_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ov_exp       = 16'h0;
        exp_bin      = 4'h0;
        exp_mag      = 32'h0;
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h0;

        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            enable       = 1'($urandom);
            sample_valid = 1'($urandom);
            sample_in    = 16'($urandom);
            tick();
        end
        check_eq("rst_mag_data", 32'(mag_data_in), 32'h0);
        check_eq("rst_peak_bin", 32'(peak_bin), 32'h0);
        check_eq("rst_peak_mag", peak_mag, 32'h0);
        check_eq("rst_peak_valid", 32'(peak_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_overrun", 32'(overrun_count), 32'h0);
        reset        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b1;
        tick();
        check_eq("idle_busy", 32'(busy), 32'h0);
        check_eq("idle_no_count", 32'(overrun_count), 32'h0);
        sample_valid = 1'b0;
        enable       = 1'b1;
        tick();
        check_eq("fill_busy", 32'(busy), 32'h1);

        // 2: single peak at bin 5
        for (int i = 0; i < FLEN; i++) frame[i] = 16'h0010;
        frame[5] = 16'h0100;
        run_frame(0, 0);
        check_eq("t2_bin", 32'(peak_bin), 32'h5);
        check_eq("t2_mag", peak_mag, 32'h100);

        // 3: DC and mirror bins ignored, tie keeps lowest bin
        for (int i = 0; i < FLEN; i++) frame[i] = 16'h0001;
        frame[0] = 16'hFFFF;
        frame[9] = 16'h7000;
        frame[3] = 16'h0200;
        frame[6] = 16'h0200;
        run_frame(0, 0);
        check_eq("t3_bin", 32'(peak_bin), 32'h3);
        check_eq("t3_mag", peak_mag, 32'h200);

        // 4: overruns during STREAM and REPORT, next frame fills right after REPORT
        for (int i = 0; i < FLEN; i++) frame[i] = 16'(i + 1);
        run_frame(0, 1);
        check_eq("t4_overrun", 32'(overrun_count), 32'h4);
        for (int i = 0; i < FLEN; i++) frame[i] = 16'(FLEN - i);
        run_frame(0, 0);

        // 5: abort a partial frame
        for (int i = 0; i < 7; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'hF000;
            tick();
        end
        sample_valid = 1'b0;
        enable       = 1'b0;
        tick();
        check_eq("abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 30; i++) begin
            sample_valid = 1'($urandom);
            if (peak_valid) check_eq("abort_pv", 32'(peak_valid), 32'h0);
            tick();
        end
        sample_valid = 1'b0;
        check_eq("abort_hold_bin", 32'(peak_bin), 32'(exp_bin));
        check_eq("abort_overrun", 32'(overrun_count), 32'(ov_exp));
        enable = 1'b1;
        tick();
        for (int i = 0; i < FLEN; i++) frame[i] = 16'h0002;
        frame[7] = 16'h0030;
        run_frame(0, 0);

        // 6: gate threshold edge (below, then exactly at level)
        for (int i = 0; i < FLEN; i++) frame[i] = 16'h0001;
        frame[4] = 16'h00FF;
        run_frame(0, 0);
        for (int i = 0; i < FLEN; i++) frame[i] = 16'h0001;
        frame[2] = 16'h0100;
        run_frame(0, 0);

        // Randomized frames with input gaps and random overruns
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < FLEN; i++) begin
                if (f == 7)              frame[i] = 16'h0;
                else if ($urandom_range(1) == 1) frame[i] = 16'($urandom);
                else                     frame[i] = 16'($urandom_range(3));
            end
            run_frame(25, 2);
        end

        // Reset in the middle of STREAM discards everything
        for (int i = 0; i < FLEN; i++) begin
            sample_valid = 1'b1;
            sample_in    = 16'hABCD;
            tick();
        end
        sample_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        check_eq("mrst_bin", 32'(peak_bin), 32'h0);
        check_eq("mrst_mag", peak_mag, 32'h0);
        check_eq("mrst_busy", 32'(busy), 32'h0);
        check_eq("mrst_overrun", 32'(overrun_count), 32'h0);
        for (int i = 0; i < 30; i++) begin
            if (peak_valid || mag_data_in != 16'h0)
                check_eq("mrst_quiet", {15'h0, peak_valid, mag_data_in}, 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
